// File: rtl/dreg_universal.sv
// dreg_universal: WIDTH-bit universal register with synchronous clear/preset,
// enable, parallel load, shift, rotate and invert, plus serial chaining taps.
module dreg_universal #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] CLEAR_VALUE  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pre,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             sout_l,
  output logic             sout_r
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INV  = 3'b110;

  logic [WIDTH-1:0] q_next;

  // Next-value selection: clr over pre over enable/mode; mode is only looked at when en=1.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = CLEAR_VALUE;
    end else if (pre) begin
      q_next = PRESET_VALUE;
    end else if (en) begin
      case (mode)
        MODE_HOLD: q_next = q;
        MODE_LOAD: q_next = d;
        MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
        MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
        MODE_INV:  q_next = ~q;
        default:   q_next = q;
      endcase
    end
  end

  // q and its complement are registered from the same next value so they never disagree.
  always_ff @(posedge clk) begin
    q    <= q_next;
    qnot <= ~q_next;
  end

  // Serial taps come straight off q so chained instances shift in the same edge.
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_dreg_universal.sv
// Self-checking bench for dreg_universal: two chained 8-bit instances, a
// behavioural model, per-cycle comparison and hand-computed spot checks.
module tb_dreg_universal;

  logic       clk = 1'b0;
  logic       clr, pre, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] d;
  logic       pre_b, en_b, sin_l_b;
  logic [2:0] mode_b;
  logic [7:0] d_b;

  logic [7:0] q_a, qnot_a, q_b, qnot_b;
  logic       sout_l_a, sout_r_a, sout_l_b, sout_r_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] ma, mb;
  logic       m_valid = 1'b0;

  always #5 clk = ~clk;

  dreg_universal #(.WIDTH(8)) u_a (
    .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q_a), .qnot(qnot_a),
    .sout_l(sout_l_a), .sout_r(sout_r_a)
  );

  dreg_universal #(.WIDTH(8)) u_b (
    .clk(clk), .clr(clr), .pre(pre_b), .en(en_b), .mode(mode_b), .d(d_b),
    .sin_l(sin_l_b), .sin_r(sout_l_a), .q(q_b), .qnot(qnot_b),
    .sout_l(sout_l_b), .sout_r(sout_r_b)
  );

  // Behavioural next value from the operation table, using plain arithmetic.
  function automatic logic [7:0] f_next(input logic [7:0] cur, input logic c, input logic p,
                                        input logic e, input logic [2:0] m, input logic [7:0] dd,
                                        input logic sl, input logic sr);
    if (c) return 8'h00;
    if (p) return 8'hFF;
    if (!e) return cur;
    case (m)
      3'd1: return dd;
      3'd2: return 8'((cur * 2) + {7'd0, sr});
      3'd3: return 8'((cur / 2) + (sl ? 8'h80 : 8'h00));
      3'd4: return 8'((cur * 2) + (cur / 128));
      3'd5: return 8'((cur / 2) + ((cur % 2) * 128));
      3'd6: return 8'(8'hFF - cur);
      default: return cur;
    endcase
  endfunction

  // Model advances on each rising edge from the inputs the DUTs saw.
  always @(posedge clk) begin
    logic [7:0] na, nb;
    na = f_next(ma, clr, pre, en, mode, d, sin_l, sin_r);
    nb = f_next(mb, clr, pre_b, en_b, mode_b, d_b, sin_l_b, ma[7]);
    ma = na;
    mb = nb;
    if (clr) m_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle once the model is defined: both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("a_q", q_a, ma);
      chk("a_qnot", qnot_a, ~ma);
      chk("a_sout_l", {7'd0, sout_l_a}, {7'd0, ma[7]});
      chk("a_sout_r", {7'd0, sout_r_a}, {7'd0, ma[0]});
      chk("b_q", q_b, mb);
      chk("b_qnot", qnot_b, ~mb);
      chk("b_sout_l", {7'd0, sout_l_b}, {7'd0, mb[7]});
      chk("b_sout_r", {7'd0, sout_r_b}, {7'd0, mb[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] v);
    en = 1'b1; mode = 3'b001; d = v;
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    clr = 1'b0; pre = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    pre_b = 1'b0; en_b = 1'b0; mode_b = 3'b000; d_b = 8'h00; sin_l_b = 1'b0;
    ma = 8'hxx; mb = 8'hxx;
    #2;

    // Reset/preset priority
    clr = 1'b1; pre = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hA5;
    tick();
    chk("clr_wins_q", q_a, 8'h00);
    chk("clr_wins_qnot", qnot_a, 8'hFF);
    chk("clr_b_q", q_b, 8'h00);
    clr = 1'b0;
    tick();
    chk("preset_q", q_a, 8'hFF);
    chk("preset_qnot", qnot_a, 8'h00);
    pre = 1'b0; en = 1'b0;
    tick();
    chk("hold_after_pre", q_a, 8'hFF);

    // Load and hold
    load_a(8'h3C);
    chk("load_3c", q_a, 8'h3C);
    en = 1'b0; d = 8'hFF;
    repeat (5) tick();
    chk("hold_5", q_a, 8'h3C);
    en = 1'b1; mode = 3'b111;
    tick();
    chk("mode_111_hold", q_a, 8'h3C);
    en = 1'b0; mode = 3'bxxx;
    tick();
    chk("x_mode_en0", q_a, 8'h3C);
    mode = 3'b000;
    // mid-cycle pulse that reverts before the edge must not be seen
    #2 en = 1'b1; mode = 3'b001; d = 8'h00;
    #2 en = 1'b0; mode = 3'b000;
    tick();
    chk("glitch_ignored", q_a, 8'h3C);

    // Shifts
    load_a(8'h81);
    mode = 3'b010; sin_r = 1'b1;
    tick();
    chk("shl_81", q_a, 8'h03);
    mode = 3'b011; sin_l = 1'b0;
    tick();
    chk("shr_03", q_a, 8'h01);
    chk("shr_sout_r", {7'd0, sout_r_a}, 8'h01);
    mode = 3'b010;
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      sin_r = pat[i];
      tick();
    end
    chk("shl_pattern", q_a, 8'hB2);
    sin_l = 1'b1; mode = 3'b011;
    tick();
    chk("shr_sin_l1", q_a, 8'hD9);

    // Rotate/invert
    load_a(8'h81);
    mode = 3'b100;
    tick();
    chk("rol_81", q_a, 8'h03);
    mode = 3'b101;
    tick();
    tick();
    chk("ror2_03", q_a, 8'hC0);
    mode = 3'b110;
    tick();
    chk("inv_q", q_a, 8'h3F);
    chk("inv_qnot", qnot_a, 8'hC0);
    mode = 3'b100;
    repeat (8) tick();
    chk("rol8_identity", q_a, 8'h3F);

    // Mid-operation clear
    load_a(8'h5A);
    mode = 3'b010; sin_r = 1'b1;
    tick();
    chk("mid_shl1", q_a, 8'hB5);
    tick();
    chk("mid_shl2", q_a, 8'h6B);
    clr = 1'b1;
    tick();
    chk("mid_clr", q_a, 8'h00);
    clr = 1'b0;
    tick();
    chk("resume_1", q_a, 8'h01);
    sin_r = 1'b0;
    tick();
    chk("resume_2", q_a, 8'h02);

    // Chaining: A.sout_l feeds B.sin_r
    en = 1'b1; mode = 3'b001; d = 8'h80;
    en_b = 1'b1; mode_b = 3'b001; d_b = 8'h00;
    tick();
    chk("chain_a_load", q_a, 8'h80);
    chk("chain_b_load", q_b, 8'h00);
    mode = 3'b010; mode_b = 3'b010; sin_r = 1'b1;
    tick();
    chk("chain_a", q_a, 8'h01);
    chk("chain_b", q_b, 8'h01);
    sin_r = 1'b0;
    repeat (7) tick();
    chk("chain_a_8", q_a, 8'h80);
    chk("chain_b_8", q_b, 8'h80);
    tick();
    chk("chain_b_carry", q_b, 8'h01);

    // Preset on B only
    en_b = 1'b0; en = 1'b0; pre_b = 1'b1;
    tick();
    chk("b_preset", q_b, 8'hFF);
    chk("a_unaffected", q_a, 8'h00);
    pre_b = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
